// File: rtl/tdm_demux_2b_if.sv
// Bus bundle for the 2-bit TDM demultiplexer: serial sample inputs plus the
// reconstructed channels and framing status.
interface tdm_demux_2b_if;
    logic En;
    logic In1, In0;
    logic Sync;
    logic A1, A0, B1, B0, C1, C0, D1, D0;
    logic S1, S0;
    logic FrameValid;
    logic SyncErr;
    logic Locked;

    modport master (
        output En, In1, In0, Sync,
        input  A1, A0, B1, B0, C1, C0, D1, D0, S1, S0, FrameValid, SyncErr, Locked
    );

    modport slave (
        input  En, In1, In0, Sync,
        output A1, A0, B1, B0, C1, C0, D1, D0, S1, S0, FrameValid, SyncErr, Locked
    );
endinterface

// File: rtl/tdm_demux_2b.sv
// Receive side of the 2-bit 4:1 TDM link: rebuilds channels A..D from the
// slot stream and publishes them atomically once per complete frame.
module tdm_demux_2b #(
    parameter bit REQUIRE_SYNC = 1'b1
) (
    input logic           Clk,
    input logic           Rst,
    tdm_demux_2b_if.slave bus
);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] sh_a, sh_b, sh_c;
    logic [1:0] sh_a_nxt, sh_b_nxt, sh_c_nxt;
    logic [1:0] out_a, out_b, out_c, out_d;
    logic [1:0] out_a_nxt, out_b_nxt, out_c_nxt, out_d_nxt;
    logic       fv, fv_nxt;
    logic       se, se_nxt;
    logic [1:0] sample;

    assign sample = {bus.In1, bus.In0};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= HUNT;
            cnt   <= 2'd0;
            sh_a  <= 2'd0;
            sh_b  <= 2'd0;
            sh_c  <= 2'd0;
            out_a <= 2'd0;
            out_b <= 2'd0;
            out_c <= 2'd0;
            out_d <= 2'd0;
            fv    <= 1'b0;
            se    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sh_a  <= sh_a_nxt;
            sh_b  <= sh_b_nxt;
            sh_c  <= sh_c_nxt;
            out_a <= out_a_nxt;
            out_b <= out_b_nxt;
            out_c <= out_c_nxt;
            out_d <= out_d_nxt;
            fv    <= fv_nxt;
            se    <= se_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_a_nxt  = sh_a;
        sh_b_nxt  = sh_b;
        sh_c_nxt  = sh_c;
        out_a_nxt = out_a;
        out_b_nxt = out_b;
        out_c_nxt = out_c;
        out_d_nxt = out_d;
        fv_nxt    = 1'b0;
        se_nxt    = 1'b0;

        if (bus.En) begin
            unique case (state)
                HUNT: begin
                    if (bus.Sync) begin
                        sh_a_nxt  = sample;
                        cnt_nxt   = 2'd1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.Sync) begin
                        // Sync anywhere but slot 0 restarts the frame; the partial frame is dropped.
                        se_nxt   = (cnt != 2'd0);
                        sh_a_nxt = sample;
                        cnt_nxt  = 2'd1;
                    end else begin
                        unique case (cnt)
                            2'd0: begin
                                if (REQUIRE_SYNC) begin
                                    se_nxt    = 1'b1;
                                    state_nxt = HUNT;
                                    cnt_nxt   = 2'd0;
                                end else begin
                                    sh_a_nxt = sample;
                                    cnt_nxt  = 2'd1;
                                end
                            end
                            2'd1: begin
                                sh_b_nxt = sample;
                                cnt_nxt  = 2'd2;
                            end
                            2'd2: begin
                                sh_c_nxt = sample;
                                cnt_nxt  = 2'd3;
                            end
                            default: begin
                                out_a_nxt = sh_a;
                                out_b_nxt = sh_b;
                                out_c_nxt = sh_c;
                                out_d_nxt = sample;
                                fv_nxt    = 1'b1;
                                cnt_nxt   = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    assign {bus.A1, bus.A0} = out_a;
    assign {bus.B1, bus.B0} = out_b;
    assign {bus.C1, bus.C0} = out_c;
    assign {bus.D1, bus.D0} = out_d;
    assign {bus.S1, bus.S0} = cnt;
    assign bus.FrameValid   = fv;
    assign bus.SyncErr      = se;
    assign bus.Locked       = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux_2b.sv
// Scoreboard bench for tdm_demux_2b: frames expected by each scenario are
// queued as stimulus is driven and matched against every FrameValid pulse.
module tb_tdm_demux_2b;
    logic Clk = 1'b0;
    logic Rst = 1'b1;

    tdm_demux_2b_if dif ();

    tdm_demux_2b #(.REQUIRE_SYNC(1'b1)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (dif.slave)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {dif.A1, dif.A0, dif.B1, dif.B0, dif.C1, dif.C0, dif.D1, dif.D0};
    endfunction

    function automatic logic [1:0] slot();
        return {dif.S1, dif.S0};
    endfunction

    // One sample slot: drive away from the edge, then check SyncErr just after it.
    task automatic step(input logic en, input logic sync, input logic [1:0] d, input logic exp_se);
        @(negedge Clk);
        dif.En   = en;
        dif.Sync = sync;
        {dif.In1, dif.In0} = d;
        @(posedge Clk);
        #1;
        chk("sync_err", {31'd0, dif.SyncErr}, {31'd0, exp_se});
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst      = 1'b1;
        dif.En   = 1'b1;
        dif.Sync = 1'b1;
        {dif.In1, dif.In0} = 2'b11;
        @(posedge Clk);
        #1;
        chk("rst_outs", {24'd0, outs()}, 32'd0);
        chk("rst_locked", {31'd0, dif.Locked}, 32'd0);
        chk("rst_slot", {30'd0, slot()}, 32'd0);
        chk("rst_fv", {31'd0, dif.FrameValid}, 32'd0);
        chk("rst_se", {31'd0, dif.SyncErr}, 32'd0);
        @(negedge Clk);
        Rst    = 1'b0;
        dif.En = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (dif.FrameValid) begin
            if (sb.size() == 0) begin
                chk("fv_unexpected", 32'd1, 32'd0);
            end else begin
                chk("frame", {24'd0, outs()}, {24'd0, sb.pop_front()});
            end
            chk("fv_se_excl", {31'd0, dif.SyncErr}, 32'd0);
        end
    end

    initial begin
        dif.En = 1'b0; dif.Sync = 1'b0; dif.In1 = 1'b0; dif.In0 = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        do_reset();

        // Basic frame 00,01,10,11
        step(1, 1, 2'b00, 0);
        chk("locked_after_sync", {31'd0, dif.Locked}, 32'd1);
        chk("slot_after_sync", {30'd0, slot()}, 32'd1);
        step(1, 0, 2'b01, 0);
        step(1, 0, 2'b10, 0);
        sb.push_back(8'h1B);
        step(1, 0, 2'b11, 0);
        chk("slot_frame_end", {30'd0, slot()}, 32'd0);
        chk("fv_after_slot3", {31'd0, dif.FrameValid}, 32'd1);

        // Back-to-back frame 11,10,01,00; previous values held until completion
        step(1, 1, 2'b11, 0);
        step(1, 0, 2'b10, 0);
        chk("hold_mid_frame", {24'd0, outs()}, 32'h1B);
        step(1, 0, 2'b01, 0);
        chk("hold_slot2", {24'd0, outs()}, 32'h1B);
        sb.push_back(8'hE4);
        step(1, 0, 2'b00, 0);

        // Early Sync after two slots resynchronises without publishing
        step(1, 1, 2'b00, 0);
        step(1, 0, 2'b01, 0);
        step(1, 1, 2'b10, 1);
        chk("early_outs", {24'd0, outs()}, 32'hE4);
        chk("early_slot", {30'd0, slot()}, 32'd1);
        chk("early_locked", {31'd0, dif.Locked}, 32'd1);
        step(1, 0, 2'b11, 0);
        step(1, 0, 2'b01, 0);
        sb.push_back(8'hB4);
        step(1, 0, 2'b00, 0);

        // Missing Sync at slot 0 drops lock
        step(1, 1, 2'b01, 0);
        step(1, 0, 2'b10, 0);
        step(1, 0, 2'b11, 0);
        sb.push_back(8'h6C);
        step(1, 0, 2'b00, 0);
        step(1, 0, 2'b10, 1);
        chk("nosync_locked", {31'd0, dif.Locked}, 32'd0);
        chk("nosync_slot", {30'd0, slot()}, 32'd0);
        step(1, 0, 2'b01, 0);
        step(1, 0, 2'b11, 0);
        step(1, 0, 2'b00, 0);
        step(1, 0, 2'b10, 0);
        chk("hunt_ignores", {31'd0, dif.Locked}, 32'd0);
        chk("hunt_slot", {30'd0, slot()}, 32'd0);
        chk("hunt_outs", {24'd0, outs()}, 32'h6C);

        // En gaps between every sample
        step(1, 1, 2'b00, 0);
        step(0, 0, 2'b11, 0);
        chk("gap_slot1", {30'd0, slot()}, 32'd1);
        step(1, 0, 2'b01, 0);
        step(0, 1, 2'b11, 0);
        step(0, 0, 2'b00, 0);
        chk("gap_slot2", {30'd0, slot()}, 32'd2);
        step(1, 0, 2'b10, 0);
        step(0, 1, 2'b01, 0);
        chk("gap_slot3", {30'd0, slot()}, 32'd3);
        sb.push_back(8'h1B);
        step(1, 0, 2'b11, 0);
        step(0, 0, 2'b10, 0);
        chk("gap_outs_hold", {24'd0, outs()}, 32'h1B);
        chk("gap_slot0", {30'd0, slot()}, 32'd0);

        // Reset after slot 2 loses the partial frame; next frame decodes
        step(1, 1, 2'b11, 0);
        step(1, 0, 2'b11, 0);
        step(1, 0, 2'b11, 0);
        do_reset();
        step(1, 1, 2'b10, 0);
        step(1, 0, 2'b01, 0);
        step(1, 0, 2'b00, 0);
        sb.push_back(8'h93);
        step(1, 0, 2'b11, 0);

        @(negedge Clk);
        dif.En = 1'b0;
        repeat (3) @(negedge Clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
